// File: rtl/jtframe_inrec.sv
// Frame-synchronous input recorder: captures one input word per frame into RAM
// and replays the stored words in place of the live inputs.
module jtframe_inrec #(
  parameter int AW = 10,
  parameter int W  = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          LVBL,
  input  logic          cmd_rec,
  input  logic          cmd_play,
  input  logic          cmd_stop,
  input  logic          abort_en,
  input  logic [W-1:0]  live_in,
  output logic [W-1:0]  game_in,
  output logic          rec_active,
  output logic          play_active,
  output logic          full,
  output logic [AW:0]   used_len,
  output logic [AW:0]   frame_cnt
);

  // state    | meaning
  // IDLE     | live inputs pass through, waiting for a command
  // ARM_REC  | recording requested, waiting for the first frame tick
  // REC      | one live word stored per frame tick
  // ARM_PLAY | playback requested, prefetching word 0, waiting for a tick
  // PLAY     | stored words replace live inputs, one per frame tick
  typedef enum logic [2:0] {IDLE, ARM_REC, REC, ARM_PLAY, PLAY} state_t;

  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW-1:0] ADDR_ONE = 1;

  state_t          state, next;
  logic            lvbl_l, tick, last_addr, play_end, live_abort;
  logic            arm_rec, arm_play, rec_tick, play_tick, held_sel;
  logic [AW-1:0]   raddr;
  logic [W-1:0]    rdata, held;
  logic [W-1:0]    mem [0:2**AW-1];

  assign tick       = !LVBL && lvbl_l;
  assign last_addr  = &frame_cnt[AW-1:0];
  assign play_end   = frame_cnt == used_len;
  assign live_abort = abort_en && (live_in != '0);

  always_ff @(posedge clk, posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      IDLE: begin
        if (!cmd_stop) begin
          if (cmd_rec)                          next = ARM_REC;
          else if (cmd_play && used_len != '0)  next = ARM_PLAY;
        end
      end
      ARM_REC, REC: begin
        if (cmd_stop)                next = IDLE;
        else if (tick && last_addr)  next = IDLE;
        else if (tick)               next = REC;
      end
      ARM_PLAY: begin
        if (cmd_stop)   next = IDLE;
        else if (tick)  next = PLAY;
      end
      PLAY: begin
        if (cmd_stop || live_abort || (tick && play_end)) next = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  always_comb begin
    rec_active  = 1'b0;
    play_active = 1'b0;
    arm_rec     = 1'b0;
    arm_play    = 1'b0;
    rec_tick    = 1'b0;
    play_tick   = 1'b0;
    held_sel    = 1'b0;
    case (state)
      IDLE: begin
        arm_rec  = !cmd_stop && cmd_rec;
        arm_play = !cmd_stop && !cmd_rec && cmd_play && used_len != '0;
      end
      ARM_REC, REC: begin
        rec_active = 1'b1;
        rec_tick   = tick && !cmd_stop;
      end
      ARM_PLAY: begin
        play_active = 1'b1;
        play_tick   = tick && !cmd_stop;
      end
      PLAY: begin
        play_active = 1'b1;
        play_tick   = tick && !cmd_stop && !live_abort && !play_end;
        // the end-of-data tick hands game_in back to live on the same edge
        held_sel    = !(tick && play_end);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk, posedge rst) begin
    if (rst) begin
      lvbl_l    <= 1'b0;
      full      <= 1'b0;
      used_len  <= '0;
      frame_cnt <= '0;
      raddr     <= '0;
      held      <= '0;
      game_in   <= '0;
    end else begin
      lvbl_l <= LVBL;
      if (arm_rec) begin
        full      <= 1'b0;
        frame_cnt <= '0;
        used_len  <= '0;
      end
      if (arm_play) begin
        raddr     <= '0;
        frame_cnt <= '0;
      end
      if (rec_tick) begin
        frame_cnt <= frame_cnt + CNT_ONE;
        used_len  <= used_len + CNT_ONE;
        if (last_addr) full <= 1'b1;
      end
      if (play_tick) begin
        held      <= rdata;
        raddr     <= raddr + ADDR_ONE;
        frame_cnt <= frame_cnt + CNT_ONE;
      end
      game_in <= play_tick ? rdata : (held_sel ? held : live_in);
    end
  end

  // RAM contents survive reset so a capture can be replayed after one
  always_ff @(posedge clk) begin
    if (rec_tick) mem[frame_cnt[AW-1:0]] <= live_in;
    rdata <= mem[raddr];
  end

endmodule

// File: tb/tb_jtframe_inrec.sv
// Directed bench for jtframe_inrec using a 4-frame RAM so overflow is reachable.
module tb_jtframe_inrec;

  localparam int AW = 2;
  localparam int W  = 16;

  logic          clk = 1'b0;
  logic          rst, LVBL, cmd_rec, cmd_play, cmd_stop, abort_en;
  logic [W-1:0]  live_in, game_in;
  logic          rec_active, play_active, full;
  logic [AW:0]   used_len, frame_cnt;

  int errors = 0;
  int checks = 0;

  jtframe_inrec #(.AW(AW), .W(W)) dut (
    .clk(clk), .rst(rst), .LVBL(LVBL),
    .cmd_rec(cmd_rec), .cmd_play(cmd_play), .cmd_stop(cmd_stop),
    .abort_en(abort_en), .live_in(live_in), .game_in(game_in),
    .rec_active(rec_active), .play_active(play_active), .full(full),
    .used_len(used_len), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // gap for prefetch, then a one-cycle LVBL low; returns just after the tick edge
  task automatic frame_tick;
    step(4);
    LVBL = 1'b0;
    step(1);
    LVBL = 1'b1;
  endtask

  task automatic pulse_rec;  cmd_rec  = 1'b1; step(1); cmd_rec  = 1'b0; endtask
  task automatic pulse_play; cmd_play = 1'b1; step(1); cmd_play = 1'b0; endtask
  task automatic pulse_stop; cmd_stop = 1'b1; step(1); cmd_stop = 1'b0; endtask

  task automatic test_reset;
    checks++;
    if ({game_in, rec_active, play_active, full, used_len, frame_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_values game_in=%h rec=%b play=%b full=%b used=%0d cnt=%0d expected all zero",
               game_in, rec_active, play_active, full, used_len, frame_cnt);
    end
  endtask

  task automatic test_empty_play;
    pulse_play;
    checks++;
    if (play_active !== 1'b0) begin
      errors++; $display("FAIL empty_play play_active=%b expected=0", play_active);
    end
    live_in = 16'h1234;
    checks++;
    if (game_in !== 16'h0000) begin
      errors++; $display("FAIL empty_latency_pre game_in=%h expected=0000", game_in);
    end
    step(1);
    checks++;
    if (game_in !== 16'h1234) begin
      errors++; $display("FAIL empty_latency game_in=%h expected=1234", game_in);
    end
    live_in = 16'h0000;
    step(1);
  endtask

  task automatic test_record_play;
    logic [W-1:0] words [3];
    words[0] = 16'h0011; words[1] = 16'h0022; words[2] = 16'h0033;
    pulse_rec;
    checks++;
    if (rec_active !== 1'b1) begin
      errors++; $display("FAIL rp_rec_active rec_active=%b expected=1", rec_active);
    end
    for (int i = 0; i < 3; i++) begin
      live_in = words[i];
      frame_tick;
      checks++;
      if (used_len !== 3'(i + 1)) begin
        errors++; $display("FAIL rp_used_len[%0d] used_len=%0d expected=%0d", i, used_len, i + 1);
      end
    end
    pulse_stop;
    checks++;
    if (rec_active !== 1'b0 || used_len !== 3'd3 || full !== 1'b0) begin
      errors++;
      $display("FAIL rp_after_stop rec=%b used=%0d full=%b expected rec=0 used=3 full=0",
               rec_active, used_len, full);
    end
    live_in = 16'h8000;
    pulse_play;
    checks++;
    if (play_active !== 1'b1 || game_in !== 16'h8000) begin
      errors++;
      $display("FAIL rp_arm_play play_active=%b game_in=%h expected play_active=1 game_in=8000",
               play_active, game_in);
    end
    for (int i = 0; i < 3; i++) begin
      frame_tick;
      checks++;
      if (game_in !== words[i]) begin
        errors++; $display("FAIL rp_frame[%0d] game_in=%h expected=%h", i, game_in, words[i]);
      end
      step(2);
      checks++;
      if (game_in !== words[i]) begin
        errors++; $display("FAIL rp_hold[%0d] game_in=%h expected=%h", i, game_in, words[i]);
      end
    end
    frame_tick;
    checks++;
    if (game_in !== 16'h8000 || play_active !== 1'b0) begin
      errors++;
      $display("FAIL rp_end game_in=%h play_active=%b expected game_in=8000 play_active=0",
               game_in, play_active);
    end
    live_in = 16'h0000;
    step(1);
  endtask

  task automatic test_priority;
    cmd_stop = 1'b1; cmd_rec = 1'b1;
    step(1);
    cmd_stop = 1'b0; cmd_rec = 1'b0;
    checks++;
    if (rec_active !== 1'b0 || used_len !== 3'd3) begin
      errors++;
      $display("FAIL prio_stop_rec rec=%b used=%0d expected rec=0 used=3", rec_active, used_len);
    end
    cmd_rec = 1'b1; cmd_play = 1'b1;
    step(1);
    cmd_rec = 1'b0; cmd_play = 1'b0;
    checks++;
    if (rec_active !== 1'b1 || play_active !== 1'b0 || used_len !== 3'd0) begin
      errors++;
      $display("FAIL prio_rec_play rec=%b play=%b used=%0d expected rec=1 play=0 used=0",
               rec_active, play_active, used_len);
    end
    pulse_stop;
    checks++;
    if (rec_active !== 1'b0) begin
      errors++; $display("FAIL prio_stop rec_active=%b expected=0", rec_active);
    end
  endtask

  task automatic test_overflow;
    pulse_rec;
    for (int i = 1; i <= 6; i++) begin
      live_in = 16'hA000 + 16'(i);
      frame_tick;
      if (i == 4) begin
        checks++;
        if (full !== 1'b1 || used_len !== 3'd4 || rec_active !== 1'b0) begin
          errors++;
          $display("FAIL ovf_4th full=%b used=%0d rec=%b expected full=1 used=4 rec=0",
                   full, used_len, rec_active);
        end
      end
    end
    checks++;
    if (used_len !== 3'd4 || frame_cnt !== 3'd4 || full !== 1'b1) begin
      errors++;
      $display("FAIL ovf_after used=%0d cnt=%0d full=%b expected used=4 cnt=4 full=1",
               used_len, frame_cnt, full);
    end
    live_in = 16'h0000;
    pulse_play;
    for (int i = 1; i <= 4; i++) begin
      frame_tick;
      checks++;
      if (game_in !== 16'hA000 + 16'(i)) begin
        errors++; $display("FAIL ovf_play[%0d] game_in=%h expected=%h", i, game_in, 16'hA000 + 16'(i));
      end
    end
    frame_tick;
    checks++;
    if (game_in !== 16'h0000 || play_active !== 1'b0) begin
      errors++;
      $display("FAIL ovf_play_end game_in=%h play=%b expected game_in=0000 play=0", game_in, play_active);
    end
  endtask

  task automatic test_abort;
    abort_en = 1'b1;
    live_in  = 16'h0000;
    pulse_play;
    frame_tick;
    checks++;
    if (game_in !== 16'hA001) begin
      errors++; $display("FAIL abort_first game_in=%h expected=a001", game_in);
    end
    live_in = 16'h0004;
    step(1);
    checks++;
    if (play_active !== 1'b0 || game_in !== 16'hA001) begin
      errors++;
      $display("FAIL abort_idle play=%b game_in=%h expected play=0 game_in=a001", play_active, game_in);
    end
    step(1);
    checks++;
    if (game_in !== 16'h0004) begin
      errors++; $display("FAIL abort_live game_in=%h expected=0004", game_in);
    end
    abort_en = 1'b0;
    live_in  = 16'h0000;
    pulse_play;
    frame_tick;
    live_in = 16'h0004;
    step(2);
    checks++;
    if (play_active !== 1'b1 || game_in !== 16'hA001) begin
      errors++;
      $display("FAIL noabort_hold play=%b game_in=%h expected play=1 game_in=a001", play_active, game_in);
    end
    frame_tick;
    checks++;
    if (game_in !== 16'hA002) begin
      errors++; $display("FAIL noabort_next game_in=%h expected=a002", game_in);
    end
    pulse_stop;
    checks++;
    if (play_active !== 1'b0) begin
      errors++; $display("FAIL noabort_stop play_active=%b expected=0", play_active);
    end
    live_in = 16'h0000;
    step(1);
  endtask

  task automatic test_reset_mid_rec;
    pulse_rec;
    live_in = 16'h0005;
    frame_tick;
    live_in = 16'h0006;
    frame_tick;
    checks++;
    if (used_len !== 3'd2 || rec_active !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre used=%0d rec=%b expected used=2 rec=1", used_len, rec_active);
    end
    #2 rst = 1'b1;
    #1;
    test_reset;
    step(1);
    rst = 1'b0;
    pulse_play;
    checks++;
    if (play_active !== 1'b0) begin
      errors++; $display("FAIL rst_play_ignored play_active=%b expected=0", play_active);
    end
    step(3);
    checks++;
    if (play_active !== 1'b0 || used_len !== 3'd0 || game_in !== 16'h0006) begin
      errors++;
      $display("FAIL rst_after play=%b used=%0d game_in=%h expected play=0 used=0 game_in=0006",
               play_active, used_len, game_in);
    end
  endtask

  initial begin
    rst = 1'b1; LVBL = 1'b1;
    cmd_rec = 1'b0; cmd_play = 1'b0; cmd_stop = 1'b0; abort_en = 1'b0;
    live_in = '0;
    #1;
    test_reset;
    step(2);
    rst = 1'b0;
    step(1);
    test_empty_play;
    test_record_play;
    test_priority;
    test_overflow;
    test_abort;
    test_reset_mid_rec;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jtframe_inrec.md
# jtframe_inrec

Frame-synchronous input record/playback sequencer for the JTFRAME input path. It sits between the merged player inputs (joystick, coin and start, active-high, before any active-low inversion) and the stage that inverts and drives the game. In record mode it stores one input word per video frame into internal RAM. In playback mode it replaces the live inputs with the stored words, one per frame, for attract-mode demos and regression captures.

## Interface
- `AW`, 10: RAM address width; capacity is 2^AW frames.
- `W`, 16: input word width.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `LVBL`  in  1  vertical blank, active low. A falling edge marks a frame boundary.
- `cmd_rec`  in  1  one-cycle pulse: request recording.
- `cmd_play`  in  1  one-cycle pulse: request playback.
- `cmd_stop`  in  1  one-cycle pulse: abort any activity.
- `abort_en`  in  1  when high, any live input ends playback.
- `live_in`  in  W  live inputs, active-high.
- `game_in`  out  W  inputs delivered to the game, registered.
- `rec_active`  out  1  high in ARM_REC or REC.
- `play_active`  out  1  high in ARM_PLAY or PLAY.
- `full`  out  1  recording stopped because the RAM filled.
- `used_len`  out  AW+1  number of frames held in RAM.
- `frame_cnt`  out  AW+1  frames recorded or played in the current session.

## Operation
- Frame tick (`tick`): the single cycle in which `LVBL`=0 and the `LVBL` value registered on the previous cycle is 1.
- RAM: 2^AW×W, one synchronous write port, one registered read port. Contents are never reset.
- States: IDLE, ARM_REC, REC, ARM_PLAY, PLAY.
- Command priority in a cycle: `cmd_stop` > `cmd_rec` > `cmd_play`. `cmd_rec` and `cmd_play` are ignored outside IDLE.
- **IDLE**
  - `cmd_rec` → ARM_REC. Clears `full`, `frame_cnt` and `used_len`.
  - `cmd_play` with `used_len`≠0 → ARM_PLAY. Sets raddr=0 and clears `frame_cnt`.
  - `cmd_play` with `used_len`=0 is ignored.
- **ARM_REC**: on `tick` → REC, and that same tick records as described for REC.
- **REC**, on each `tick`:
  - Write `live_in` to mem[waddr], where waddr = `frame_cnt`[AW-1:0].
  - Increment `frame_cnt` and `used_len`.
  - After writing address 2^AW-1: `used_len`=2^AW, `full`=1, go to IDLE.
- **ARM_PLAY**: the read data is prefetched continuously from mem[raddr]. On `tick` → PLAY, and that same tick plays as described for PLAY.
- **PLAY**, on each `tick`:
  - If `frame_cnt`=`used_len`: go to IDLE; `game_in` follows live from this tick.
  - Otherwise: latch mem[raddr] into the held word, increment raddr and `frame_cnt`.
- **Live abort**: in PLAY with `abort_en`=1 and `live_in`≠0, go to IDLE on the next cycle, independent of `tick`.
- **`cmd_stop`**: from any state → IDLE on the next cycle.
  - In REC, `used_len` keeps the number of frames already written.
  - `full` is unchanged.
- **Output mux**: every cycle, `game_in` <= PLAY ? held word : `live_in`. In ARM_PLAY it still follows live.

## Timing
- Reset values: state IDLE, `game_in`=0, `rec_active`=0, `play_active`=0, `full`=0, `used_len`=0, `frame_cnt`=0, waddr=raddr=0, held word 0.
- Reset mid-session aborts immediately and sets `used_len`=0; the RAM is not cleared.
- Live path latency: 1 cycle from `live_in` to `game_in`.
- Record: the word written is `live_in` sampled in the `tick` cycle.
- Playback: the stored word for frame k appears on `game_in` 1 cycle after the k-th `tick` following the arm.
  - The last stored word is held until the next `tick`.
  - `game_in` returns to live 1 cycle after that `tick`.
- Prefetch: raddr updates on `tick`; read data is valid 2 cycles later. Frames are thousands of cycles long, so no stall logic is needed.
- `rec_active` and `play_active` change 1 cycle after the causing command or `tick`.
- A command coinciding with `tick` in IDLE only arms; the first capture or playback happens on the following `tick`.
- `LVBL` held low (no edges): the block stays in ARM or the active state indefinitely.

## Test plan
- Record then play:
  - Stimulus: `cmd_rec`, then `live_in`=0x0011, 0x0022, 0x0033 at 3 ticks; `cmd_stop`; set `live_in`=0x8000; `cmd_play`.
  - Required: `used_len`=3; `game_in` shows 0x0011, 0x0022, 0x0033 on successive ticks, then 0x8000 from the 4th tick; `play_active` falls.
- Empty play: `cmd_play` right after reset → stays IDLE, `play_active`=0, `game_in` tracks `live_in` with 1-cycle latency.
- Overflow (AW=2): record 6 ticks → exactly 4 writes, `full`=1, `used_len`=4, `rec_active`=0 after the 4th tick.
- Priority: `cmd_stop`+`cmd_rec` in the same IDLE cycle → stays IDLE; `cmd_rec`+`cmd_play` together → ARM_REC.
- Live abort: in PLAY with `abort_en`=1, set `live_in`=0x0004 → IDLE next cycle, `game_in`=0x0004 one cycle later. Repeat with `abort_en`=0 → playback continues.
- Async reset mid-REC: assert `rst` after 2 ticks → all outputs at reset values immediately; a following `cmd_play` is ignored.
